// File: rtl/dpram_read_arbiter_pkg.sv
// Shared definitions for the line-buffer read path.
//   log2()       : address width for a count of items, never less than 1 bit
//   elm_width()  : width of an element select for a row of 'words' elements
//   rd_tag_t     : one latency-pipe stage, {valid, requester id}
// No ports.
package globalDefinitions;

    // Ceiling log2 with a floor of 1, so a count of 1 still yields a usable
    // 1-bit select instead of a zero-width vector.
    function automatic int log2(input int value);
        int result;
        result = 1;
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) < value) begin
                result = w + 1;
            end
        end
        return result;
    endfunction

    // Element-select width is the log2 of the number of elements per row.
    function automatic int elm_width(input int words);
        return log2(words);
    endfunction

    // Widest requester id carried in the latency pipe (up to 256 requesters).
    // Narrower ids are zero-extended into it.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/dpram_read_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high; pointer returns to 0
//   eligible     in   [N] requesters that may be granted this cycle
//   grant_valid  out  some requester is granted this cycle
//   grant_idx    out  index of the granted requester (0 when none)
module rr_arbiter
    import globalDefinitions::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         eligible,
    output logic                 grant_valid,
    output logic [log2(N)-1:0]   grant_idx
);

    localparam int IDX_W = log2(N);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to the pointer so the candidate
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
            if (cand_sum >= (IDX_W + 1)'(N)) begin
                cand_sum = cand_sum - (IDX_W + 1)'(N);
            end
            cand = cand_sum[IDX_W-1:0];
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves one past the winner. With N == 1 the winner is always
    // N-1, so the pointer stays at 0.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            if (int'(grant_idx) == N - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/dpram_read_arbiter.sv
// Round-robin read-port arbiter for a banked simple dual-port line-buffer RAM.
// One read issued per cycle; each result is routed back to its issuer after
// READ_LATENCY cycles. Reads to the row being written this cycle can be held off.
//   clk, reset            clock / asynchronous active-high reset
//   req_valid/ready       per-requester handshake (ready is one-hot or zero)
//   req_addr, req_elm     per-requester row address and element select
//   wr_we, wr_addr        snooped RAM write port
//   ram_raddr(_elm)       read address to the RAM, held between grants
//   ram_q                 RAM read data (full row)
//   rsp_valid, rsp_data   one-hot response strobe and the forwarded row
module dpram_read_arbiter
    import globalDefinitions::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 1,
    parameter int WORD_SIZE    = 1,
    parameter int WORDS        = 1,
    parameter int READ_LATENCY = 1,
    parameter int HAZARD_STALL = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ-1:0][elm_width(WORDS)-1:0]  req_elm,
    input  logic                                      wr_we,
    input  logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic [ADDR_WIDTH-1:0]                     ram_raddr,
    output logic [elm_width(WORDS)-1:0]               ram_raddr_elm,
    input  logic [WORDS-1:0][WORD_SIZE-1:0]           ram_q,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [WORDS-1:0][WORD_SIZE-1:0]           rsp_data
);

    localparam int ELM_W = elm_width(WORDS);
    localparam int IDX_W = log2(NUM_REQ);

    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_valid;
    logic                  grant_ok;
    logic [IDX_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] raddr_hold_reg;
    logic [ELM_W-1:0]      elm_hold_reg;
    rd_tag_t               issue_tag;
    rd_tag_t               tag_pipe_reg [READ_LATENCY];
    rd_tag_t               out_tag;

    genvar gi;

    // A requester targeting the row being written this cycle sits out the
    // arbitration; it neither wins nor disturbs the rotation.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_eligible
            assign eligible[gi] = req_valid[gi] &&
                !((HAZARD_STALL != 0) && wr_we && (req_addr[gi] == wr_addr));
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .eligible    (eligible),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // The grant path is combinational, so mask it while reset is held to
    // keep ready low and the RAM address at 0.
    assign grant_ok = grant_valid && !reset;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_ok && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Idle cycles replay the last issued address so the RAM input stays quiet.
    always_comb begin
        ram_raddr     = raddr_hold_reg;
        ram_raddr_elm = elm_hold_reg;
        if (reset) begin
            ram_raddr     = '0;
            ram_raddr_elm = '0;
        end else if (grant_ok) begin
            ram_raddr     = req_addr[grant_idx];
            ram_raddr_elm = req_elm[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr_hold_reg <= '0;
            elm_hold_reg   <= '0;
        end else if (grant_ok) begin
            raddr_hold_reg <= req_addr[grant_idx];
            elm_hold_reg   <= req_elm[grant_idx];
        end
    end

    // Latency pipe: the tag entering stage 0 at the end of the issue cycle
    // leaves the last stage exactly when the RAM presents that read's data.
    assign issue_tag = '{valid: grant_ok, id: TAG_ID_W'(grant_idx)};

    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        tag_pipe_reg[gi] <= '0;
                    end else begin
                        tag_pipe_reg[gi] <= issue_tag;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        tag_pipe_reg[gi] <= '0;
                    end else begin
                        tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_tag = tag_pipe_reg[READ_LATENCY-1];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = out_tag.valid && (out_tag.id == TAG_ID_W'(gi));
        end
    endgenerate

    assign rsp_data = ram_q;

endmodule
